// File: rtl/rv32m_div_unit_if.sv
// rtl/rv32m_div_unit_if.sv - request/response bundle between EX and the RV32M divider
interface rv32m_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             i_valid;
   logic             o_ready;
   logic [1:0]       i_div_op;
   logic [WIDTH-1:0] i_rs1_data;
   logic [WIDTH-1:0] i_rs2_data;
   logic             i_flush;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_result;
   logic             o_busy;

   modport master (
      output i_valid, i_div_op, i_rs1_data, i_rs2_data, i_flush, i_ready,
      input  o_ready, o_valid, o_result, o_busy
   );

   modport slave (
      input  i_valid, i_div_op, i_rs1_data, i_rs2_data, i_flush, i_ready,
      output o_ready, o_valid, o_result, o_busy
   );
endinterface

// File: rtl/rv32m_div_unit.sv
// rtl/rv32m_div_unit.sv - radix-2 restoring divider for DIV/DIVU/REM/REMU
// Optional result reuse for repeated operands: RV32M_DIV_RESULT_CACHE_EN
module rv32m_div_unit #(
   parameter int WIDTH = 32
) (
   input logic                 i_clk,
   input logic                 i_rst,
   rv32m_div_unit_if.slave     bus
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state, state_nxt;
   logic [5:0]       cnt;
   logic [WIDTH-1:0] rem_q, quot_q, dvs_q;
   logic             sel_rem_q, neg_a_q, neg_b_q;

   logic             is_signed, a_neg, b_neg, div_zero, ovf, hit, short_path, accept;
   logic [WIDTH-1:0] a_mag, b_mag, init_quot, init_rem;
   logic [WIDTH:0]   upper;
   logic [WIDTH+1:0] diff;
   logic             ge;
   logic [WIDTH-1:0] rem_step, quot_step, rem_fix, quot_fix;

`ifdef RV32M_DIV_RESULT_CACHE_EN
   logic             c_vld, c_signed, signed_q;
   logic [WIDTH-1:0] c_rs1, c_rs2, c_quot, c_rem, raw_a_q, raw_b_q;
`endif

   assign accept    = bus.i_valid && (state == IDLE) && !bus.i_flush;
   assign is_signed = ~bus.i_div_op[0];
   assign a_neg     = is_signed & bus.i_rs1_data[WIDTH-1];
   assign b_neg     = is_signed & bus.i_rs2_data[WIDTH-1];
   assign a_mag     = a_neg ? -bus.i_rs1_data : bus.i_rs1_data;
   assign b_mag     = b_neg ? -bus.i_rs2_data : bus.i_rs2_data;
   assign div_zero  = (bus.i_rs2_data == '0);
   assign ovf       = is_signed && (bus.i_rs1_data == INT_MIN) && (bus.i_rs2_data == '1);

`ifdef RV32M_DIV_RESULT_CACHE_EN
   assign hit = c_vld && (c_rs1 == bus.i_rs1_data) && (c_rs2 == bus.i_rs2_data)
                && (c_signed == is_signed);
`else
   assign hit = 1'b0;
`endif
   assign short_path = div_zero | ovf | hit;

   always_comb begin
      init_quot = a_mag;
      init_rem  = '0;
      if (div_zero) begin
         init_quot = '1;
         init_rem  = bus.i_rs1_data;
      end else if (ovf) begin
         init_quot = INT_MIN;
      end
`ifdef RV32M_DIV_RESULT_CACHE_EN
      else if (hit) begin
         init_quot = c_quot;
         init_rem  = c_rem;
      end
`endif
   end

   // One restoring step on {rem,quot}; the partial remainder stays below the divisor, so WIDTH bits suffice.
   assign upper     = {rem_q, quot_q[WIDTH-1]};
   assign diff      = {1'b0, upper} - {2'b00, dvs_q};
   assign ge        = ~diff[WIDTH+1];
   assign rem_step  = ge ? diff[WIDTH-1:0] : upper[WIDTH-1:0];
   assign quot_step = {quot_q[WIDTH-2:0], ge};
   assign quot_fix  = (neg_a_q ^ neg_b_q) ? -quot_step : quot_step;
   assign rem_fix   = neg_a_q ? -rem_step : rem_step;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = short_path ? DONE : CALC;
         CALC:    if (cnt == 6'd31) state_nxt = DONE;
         DONE:    if (bus.i_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (bus.i_flush) state_nxt = IDLE;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt       <= '0;
         rem_q     <= '0;
         quot_q    <= '0;
         dvs_q     <= '0;
         sel_rem_q <= 1'b0;
         neg_a_q   <= 1'b0;
         neg_b_q   <= 1'b0;
      end else if (accept) begin
         cnt       <= '0;
         rem_q     <= init_rem;
         quot_q    <= init_quot;
         dvs_q     <= b_mag;
         sel_rem_q <= bus.i_div_op[1];
         neg_a_q   <= a_neg;
         neg_b_q   <= b_neg;
      end else if (state == CALC) begin
         cnt <= cnt + 6'd1;
         if (cnt == 6'd31) begin
            rem_q  <= rem_fix;
            quot_q <= quot_fix;
         end else begin
            rem_q  <= rem_step;
            quot_q <= quot_step;
         end
      end
   end

`ifdef RV32M_DIV_RESULT_CACHE_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         c_vld    <= 1'b0;
         c_signed <= 1'b0;
         signed_q <= 1'b0;
         c_rs1    <= '0;
         c_rs2    <= '0;
         c_quot   <= '0;
         c_rem    <= '0;
         raw_a_q  <= '0;
         raw_b_q  <= '0;
      end else if (bus.i_flush) begin
         c_vld <= 1'b0;
      end else if (accept) begin
         raw_a_q  <= bus.i_rs1_data;
         raw_b_q  <= bus.i_rs2_data;
         signed_q <= is_signed;
         if (div_zero || ovf) begin
            c_vld    <= 1'b1;
            c_rs1    <= bus.i_rs1_data;
            c_rs2    <= bus.i_rs2_data;
            c_signed <= is_signed;
            c_quot   <= init_quot;
            c_rem    <= init_rem;
         end
      end else if (state == CALC && cnt == 6'd31) begin
         c_vld    <= 1'b1;
         c_rs1    <= raw_a_q;
         c_rs2    <= raw_b_q;
         c_signed <= signed_q;
         c_quot   <= quot_fix;
         c_rem    <= rem_fix;
      end
   end
`endif

   assign bus.o_ready  = (state == IDLE);
   assign bus.o_busy   = (state != IDLE);
   assign bus.o_valid  = (state == DONE);
   assign bus.o_result = (state == DONE) ? (sel_rem_q ? rem_q : quot_q) : '0;
endmodule
